// File: rtl/sample_mem_writer.sv
// sample_mem_writer
//   Buffers sample packets from the packet generator in a small FIFO. Each
//   packet is split into memory words, least-significant word first. The
//   words are written to the memory controller over a req/ack handshake.
//   The first word of a packet goes to address sample_number*WPP, and the
//   following words go to the next consecutive addresses.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   clear             start-of-capture flush (FIFO, in-flight write, overflow)
//   in_valid          packet strobe from the generator
//   in_packet         packet data
//   in_sample_number  sample number tagging in_packet
//   mem_req/addr/data write request, word address and data to the controller
//   mem_ack           controller accepts the current word
//   fifo_level        number of FIFO entries held
//   drained           FIFO empty and no write in flight
//   overflow          sticky flag: a packet was dropped on a full FIFO
module sample_mem_writer #(
  parameter int SAMPLE_PACKET_WIDTH = 32,
  parameter int MEMORY_WORD_WIDTH   = 2,
  parameter int FIFO_DEPTH          = 16,
  parameter int MEM_ADDR_WIDTH      = 26
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             in_valid,
  input  logic [SAMPLE_PACKET_WIDTH-1:0]   in_packet,
  input  logic [31:0]                      in_sample_number,
  output logic                             mem_req,
  output logic [MEM_ADDR_WIDTH-1:0]        mem_addr,
  output logic [MEMORY_WORD_WIDTH*8-1:0]   mem_data,
  input  logic                             mem_ack,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             drained,
  output logic                             overflow
);

  localparam int DW  = MEMORY_WORD_WIDTH * 8;
  localparam int WPP = SAMPLE_PACKET_WIDTH / DW;
  localparam int EW  = 32 + SAMPLE_PACKET_WIDTH;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;
  localparam int IW  = (WPP > 1) ? $clog2(WPP) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;

  state_t                         state;
  state_t                         state_next;
  logic [EW-1:0]                  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]                  wr_ptr;
  logic [PW-1:0]                  rd_ptr;
  logic [LW-1:0]                  level_next;
  logic [SAMPLE_PACKET_WIDTH-1:0] pkt_rest;
  logic [IW-1:0]                  word_idx;
  logic [31:0]                    head_sample;
  logic [SAMPLE_PACKET_WIDTH-1:0] head_packet;
  logic                           pop;
  logic                           push;
  logic                           last_word;

  assign head_sample = fifo_mem[rd_ptr][EW-1 -: 32];
  assign head_packet = fifo_mem[rd_ptr][SAMPLE_PACKET_WIDTH-1:0];

  // The head entry leaves the FIFO on the LOAD edge. A push on that same
  // edge is accepted even when the FIFO is full, because the popped slot
  // frees up space for it.
  assign pop       = (state == LOAD);
  assign push      = in_valid && ((fifo_level < LW'(FIFO_DEPTH)) || pop);
  assign last_word = (word_idx == IW'(WPP - 1));

  always_comb begin
    level_next = fifo_level;
    if (push && !pop)
      level_next = fifo_level + LW'(1);
    else if (pop && !push)
      level_next = fifo_level - LW'(1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fifo_level != '0) state_next = LOAD;
      LOAD:    state_next = WRITE;
      WRITE:   if (mem_ack && last_word) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Storage needs no reset. After a reset or clear the pointers and the
  // level say the FIFO is empty, so any stale contents are never read.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {in_sample_number, in_packet};
  end

  // drained is computed from the next level and the next state. This gives
  // it the same one-edge timing as fifo_level.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drained    <= 1'b1;
      overflow   <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      word_idx   <= '0;
      pkt_rest   <= '0;
    end else if (clear) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drained    <= 1'b1;
      overflow   <= 1'b0;
      mem_req    <= 1'b0;
    end else begin
      state      <= state_next;
      fifo_level <= level_next;
      drained    <= (level_next == '0) && (state_next == IDLE);
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (in_valid && !push)
        overflow <= 1'b1;
      case (state)
        LOAD: begin
          word_idx <= '0;
          mem_addr <= MEM_ADDR_WIDTH'(head_sample) * MEM_ADDR_WIDTH'(WPP);
          mem_data <= head_packet[DW-1:0];
          pkt_rest <= head_packet >> DW;
          mem_req  <= 1'b1;
        end
        WRITE: begin
          if (mem_ack) begin
            if (!last_word) begin
              word_idx <= word_idx + IW'(1);
              mem_addr <= mem_addr + MEM_ADDR_WIDTH'(1);
              mem_data <= pkt_rest[DW-1:0];
              pkt_rest <= pkt_rest >> DW;
            end else begin
              mem_req <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_mem_writer.sv
// tb_sample_mem_writer
//   Self-checking bench for sample_mem_writer with the default parameters
//   (32-bit packets, 16-bit words, 16-entry FIFO, 26-bit addresses).
//   A table of per-cycle vectors covers the single-packet write, an ack
//   stall and address wrap. Hand-written sequences then cover overflow, a
//   push on a full FIFO during the pop cycle, clear mid-write and reset
//   mid-write.
module tb_sample_mem_writer;

  localparam int AW = 26;
  localparam int DW = 16;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          in_valid;
  logic [31:0]   in_packet;
  logic [31:0]   in_sample_number;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ack;
  logic [LW-1:0] fifo_level;
  logic          drained;
  logic          overflow;

  int vec_count  = 0;
  int miss_count = 0;

  always #5 clk = ~clk;

  sample_mem_writer #(
    .SAMPLE_PACKET_WIDTH(32),
    .MEMORY_WORD_WIDTH(2),
    .FIFO_DEPTH(16),
    .MEM_ADDR_WIDTH(26)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .in_valid(in_valid),
    .in_packet(in_packet),
    .in_sample_number(in_sample_number),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_ack(mem_ack),
    .fifo_level(fifo_level),
    .drained(drained),
    .overflow(overflow)
  );

  typedef struct {
    logic          clr;
    logic          v;
    logic [31:0]   pkt;
    logic [31:0]   sn;
    logic          ack;
    logic          req;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [LW-1:0] lvl;
    logic          drn;
    logic          ovf;
  } vec_t;

  vec_t vecs [30];

  // Record every accepted word while enabled, as {addr, data}.
  logic              mon_en = 1'b0;
  logic [AW+DW-1:0]  wr_q [$];

  always @(posedge clk) begin
    if (mon_en && mem_req && mem_ack)
      wr_q.push_back({mem_addr, mem_data});
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic clr, input logic v, input logic [31:0] pkt,
                                input logic [31:0] sn, input logic ack);
    clear            = clr;
    in_valid         = v;
    in_packet        = pkt;
    in_sample_number = sn;
    mem_ack          = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic req, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [LW-1:0] lvl,
                           input logic drn, input logic ovf);
    check_output({tag, " mem_req"},    64'(mem_req),    64'(req));
    check_output({tag, " mem_addr"},   64'(mem_addr),   64'(addr));
    check_output({tag, " mem_data"},   64'(mem_data),   64'(data));
    check_output({tag, " fifo_level"}, 64'(fifo_level), 64'(lvl));
    check_output({tag, " drained"},    64'(drained),    64'(drn));
    check_output({tag, " overflow"},   64'(overflow),   64'(ovf));
  endtask

  function automatic logic [31:0] pkt_of(input int i);
    return {16'hA000 | 16'(i), 16'h5000 | 16'(i)};
  endfunction

  function automatic logic [31:0] sn_of(input int i);
    return 32'(200 + i);
  endfunction

  initial begin
    // clr, v, pkt, sn, ack | req, addr, data, lvl, drained, overflow
    vecs[0]  = '{1'b0, 1'b1, 32'hABCD1234, 32'd5, 1'b1, 1'b0, 26'd0,  16'h0000, 5'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 1'b0, 26'd0,  16'h0000, 5'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 1'b1, 26'd10, 16'h1234, 5'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 1'b1, 26'd11, 16'hABCD, 5'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 1'b0, 26'd11, 16'hABCD, 5'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 1'b0, 26'd11, 16'hABCD, 5'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h55667788, 32'd7, 1'b0, 1'b0, 26'd11, 16'hABCD, 5'd1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 26'd11, 16'hABCD, 5'd1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 26'd14, 16'h7788, 5'd0, 1'b0, 1'b0};
    for (int i = 9; i <= 15; i++)
      vecs[i] = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 26'd14, 16'h7788, 5'd0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 1'b1, 26'd15, 16'h5566, 5'd0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 26'd15, 16'h5566, 5'd0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 26'd15, 16'h5566, 5'd0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 1'b0, 26'd15, 16'h5566, 5'd0, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 1'b0, 26'd15, 16'h5566, 5'd0, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 32'hCAFEBEEF, 32'h01FFFFFF, 1'b1, 1'b0, 26'd15, 16'h5566, 5'd1, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 32'h0BAD0F00, 32'd0, 1'b1, 1'b0, 26'd15, 16'h5566, 5'd2, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 1'b1, 26'h3FFFFFE, 16'hBEEF, 5'd1, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 1'b1, 26'h3FFFFFF, 16'hCAFE, 5'd1, 1'b0, 1'b0};
    vecs[25] = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 1'b0, 26'h3FFFFFF, 16'hCAFE, 5'd1, 1'b0, 1'b0};
    vecs[26] = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 1'b0, 26'h3FFFFFF, 16'hCAFE, 5'd1, 1'b0, 1'b0};
    vecs[27] = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 1'b1, 26'd0, 16'h0F00, 5'd0, 1'b0, 1'b0};
    vecs[28] = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 1'b1, 26'd1, 16'h0BAD, 5'd0, 1'b0, 1'b0};
    vecs[29] = '{1'b0, 1'b0, 32'h0, 32'd0, 1'b1, 1'b0, 26'd1, 16'h0BAD, 5'd0, 1'b1, 1'b0};

    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_all("reset", 1'b0, '0, '0, '0, 1'b1, 1'b0);
    reset = 1'b0;

    // Table: single packet, ack stall, address wrap.
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].clr, vecs[i].v, vecs[i].pkt, vecs[i].sn, vecs[i].ack);
      check_all($sformatf("row%0d", i), vecs[i].req, vecs[i].addr, vecs[i].data,
                vecs[i].lvl, vecs[i].drn, vecs[i].ovf);
    end

    // Fill: packet 0 goes in flight and packets 1..16 fill the FIFO.
    wr_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i <= 16; i++)
      apply_stimulus(1'b0, 1'b1, pkt_of(i), sn_of(i), 1'b0);
    check_all("fill", 1'b1, AW'(sn_of(0) * 2), pkt_of(0) & 32'hFFFF, 5'd16, 1'b0, 1'b0);

    // Finish packet 0, idle through IDLE, then push during the LOAD edge.
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check_output("pkt0 done mem_req", 64'(mem_req), 64'(1'b0));
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 1'b1, pkt_of(17), sn_of(17), 1'b0);
    check_output("pop push level",    64'(fifo_level), 64'd16);
    check_output("pop push overflow", 64'(overflow),   64'd0);
    check_output("pop push mem_req",  64'(mem_req),    64'd1);

    // Push on a full FIFO with no pop is dropped.
    apply_stimulus(1'b0, 1'b1, pkt_of(18), sn_of(18), 1'b0);
    check_output("drop level",    64'(fifo_level), 64'd16);
    check_output("drop overflow", 64'(overflow),   64'd1);

    begin
      int cyc = 0;
      mem_ack  = 1'b1;
      in_valid = 1'b0;
      while (!drained && cyc < 500) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      check_output("drain timeout", 64'(drained), 64'd1);
    end
    mon_en = 1'b0;
    check_output("write count", 64'(wr_q.size()), 64'd36);
    for (int i = 0; i <= 17; i++) begin
      logic [AW+DW-1:0] exp0;
      logic [AW+DW-1:0] exp1;
      logic [31:0]      p;
      p    = pkt_of(i);
      exp0 = {AW'(sn_of(i) * 2), p[15:0]};
      exp1 = {AW'(sn_of(i) * 2 + 1), p[31:16]};
      if (wr_q.size() >= 2 * i + 2) begin
        check_output($sformatf("pkt%0d word0", i), 64'(wr_q[2*i]),     64'(exp0));
        check_output($sformatf("pkt%0d word1", i), 64'(wr_q[2*i + 1]), 64'(exp1));
      end
    end

    // clear with three entries queued behind an in-flight word.
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b0, 1'b1, pkt_of(40 + i), sn_of(40 + i), 1'b0);
    check_output("pre-clear level",    64'(fifo_level), 64'd3);
    check_output("pre-clear overflow", 64'(overflow),   64'd1);
    check_output("pre-clear mem_req",  64'(mem_req),    64'd1);
    apply_stimulus(1'b1, 1'b1, pkt_of(50), sn_of(50), 1'b0);
    check_output("clear mem_req",    64'(mem_req),    64'd0);
    check_output("clear level",      64'(fifo_level), 64'd0);
    check_output("clear drained",    64'(drained),    64'd1);
    check_output("clear overflow",   64'(overflow),   64'd0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check_output("post-clear mem_req", 64'(mem_req),    64'd0);
    check_output("post-clear level",   64'(fifo_level), 64'd0);
    check_output("post-clear drained", 64'(drained),    64'd1);

    // reset in the middle of a write also zeroes address and data.
    apply_stimulus(1'b0, 1'b1, 32'h11112222, 32'd50, 1'b0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_output("pre-reset mem_addr", 64'(mem_addr), 64'd100);
    check_output("pre-reset mem_data", 64'(mem_data), 64'h2222);
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_all("mid reset", 1'b0, '0, '0, '0, 1'b1, 1'b0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
